usb_ep_out_reader: RTL
======================

# usb_ep_out_reader

Drains the host-to-device OUT endpoint FIFO of `usb1_top` (endpoint 2) and assembles the byte stream into fixed-length little-endian frames for board logic. Each frame is presented downstream with a valid/ready handshake. The block sits between `usb1_top` and the Nexys3 user logic and is the receive-side counterpart of the IN-endpoint (ep1) writer. Partial frames are discarded on an inter-byte timeout, and frames are counted.

## Interface
- `FRAME_BYTES`, 4: bytes per frame, range 1..8.
- `TIMEOUT_CYCLES`, 48000: idle cycles allowed mid-frame before the partial frame is discarded (1 ms at 48 MHz), range ≥ 2.

Ports (clock and reset first):
- `clk_i`  in  1  single clock for the block.
- `rst_i`  in  1  reset, synchronous, active-high.
- `ep2_dout`  in  8  FIFO read data; valid the cycle after `ep2_re` is high.
- `ep2_empty`  in  1  FIFO empty flag.
- `ep2_re`  out  1  FIFO read enable; registered; one-cycle pulses only.
- `frame_data`  out  8*FRAME_BYTES  assembled frame; first received byte in [7:0].
- `frame_valid`  out  1  frame available; held until accepted.
- `frame_ready`  in  1  downstream accept.
- `frame_count`  out  16  accepted-frame counter; wraps.
- `timeout_err`  out  1  one-cycle pulse when a partial frame is discarded.
- `led`  out  8  board LED drive (see Configuration).

## Operation
- States:
  - IDLE: if `FRAME_BYTES` bytes are not held and `ep2_empty`=0, the next state is RD with `ep2_re`=1.
  - RD: `ep2_re` is high this cycle. Next state is CAP with `ep2_re`=0.
  - CAP: `ep2_dout` is valid. At the edge, the byte is stored at `frame_data[8*idx +: 8]` and `idx` increments. Next state is OUT if `idx` was `FRAME_BYTES-1`, else IDLE.
  - OUT: `frame_valid`=1 and no FIFO reads are issued. When `frame_ready`=1, at the edge: `frame_valid`=0, `frame_count`+1, `idx`=0, next state IDLE.
- `frame_data` is stable from `frame_valid` rising until the handshake. Bytes not yet written in a frame hold their values from the previous frame.
- Timeout counter `to_cnt`:
  - Increments each cycle in IDLE while `idx`≠0 and `ep2_empty`=1.
  - Clears on every byte store and whenever `idx`=0.
  - When `to_cnt`=`TIMEOUT_CYCLES-1` in IDLE with `ep2_empty`=1, the next edge sets `idx`=0, clears `to_cnt` and pulses `timeout_err` for one cycle. `frame_data` is not cleared.
  - If `ep2_empty` falls in the same cycle the count is reached, the read wins and no timeout occurs.
- `frame_count` wraps from 16'hFFFF to 16'h0000. It counts accepted frames only; discarded partial frames are not counted.
- Reset mid-frame: the partial frame is lost. A byte already popped by `ep2_re` but not yet captured is lost.

## Timing
- Reset values: `ep2_re`=0, `frame_valid`=0, `frame_data`=0, `frame_count`=0, `timeout_err`=0, `led`=8'b1000_0001; state IDLE, `idx`=0, `to_cnt`=0.
- Throughput: 3 cycles per byte.
- Latency: with the FIFO continuously non-empty, IDLE sampling `ep2_empty`=0 in cycle 0 gives `frame_valid`=1 in cycle `3*FRAME_BYTES` (cycle 12 at the default).
- Handshake:
  - `frame_valid` never drops without `frame_ready`.
  - The earliest next `ep2_re` is the cycle after the handshake edge plus one (IDLE, then RD).
  - `frame_ready` is ignored outside OUT.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- Macro `USB_EP_OUT_LED_EN`:
  - Defined: `led` loads the byte stored in each CAP, so it shows the last received byte. It resets to 8'b1000_0001.
  - Undefined: `led` is constant 8'b1000_0001 and the byte-capture logic for `led` is not compiled in.

## Test plan
- Bytes 0x11, 0x22, 0x33, 0x44 in the FIFO, `frame_ready`=1 → `frame_data`=32'h44332211 and `frame_valid` high in cycle 12 for exactly one cycle. `frame_count`=1. `ep2_re` pulses 4 times, each exactly one cycle.
- Eight bytes 0x01..0x08 queued, `frame_ready` held low for 20 cycles → first frame 32'h04030201 stays stable with `frame_valid` high and no `ep2_re` during the stall. After release, the second frame is 32'h08070605 and `frame_count`=2.
- Two bytes 0xAA, 0xBB then FIFO empty, `TIMEOUT_CYCLES`=10 → `timeout_err` pulses once, 10 idle cycles after the second byte is stored, and `frame_valid` never rises. Then 0x01..0x04 → 32'h04030201.
- `frame_count` forced near wrap via 65536 accepted frames (or `FRAME_BYTES`=1 with a long stream) → count goes 16'hFFFF → 16'h0000 with no glitch on other outputs.
- `rst_i` high for 1 cycle after 3 bytes of a frame → all outputs return to reset values the next cycle. The next 4 bytes form a complete new frame.
- With `USB_EP_OUT_LED_EN` defined, stream 0x5A → `led`=8'h5A after CAP. Undefined, same stream → `led` stays 8'b1000_0001.

Source files
------------

// File: rtl/usb_ep_out_reader.sv
// Drains the ep2 OUT FIFO of usb1_top into little-endian FRAME_BYTES frames with valid/ready,
// inter-byte timeout discard and an accepted-frame counter. Optional macro: USB_EP_OUT_LED_EN.
module usb_ep_out_reader #(
   parameter int FRAME_BYTES    = 4,
   parameter int TIMEOUT_CYCLES = 48000
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [7:0]               ep2_dout,
   input  logic                     ep2_empty,
   output logic                     ep2_re,
   output logic [8*FRAME_BYTES-1:0] frame_data,
   output logic                     frame_valid,
   input  logic                     frame_ready,
   output logic [15:0]              frame_count,
   output logic                     timeout_err,
   output logic [7:0]               led
);

   localparam int IDX_W = $clog2(FRAME_BYTES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);
   localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]       LED_RST  = 8'b1000_0001;

   typedef enum logic [1:0] {S_IDLE, S_RD, S_CAP, S_OUT} state_t;

   state_t           state, state_n;
   logic [IDX_W-1:0] idx;
   logic [TO_W-1:0]  to_cnt;
   logic             rd_go, store, last, handshake, to_fire, to_inc;

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= state_n;
   end

   // A pending read beats an expiring timeout: the empty check comes first.
   always_comb begin
      state_n   = state;
      rd_go     = 1'b0;
      store     = 1'b0;
      last      = 1'b0;
      handshake = 1'b0;
      to_fire   = 1'b0;
      to_inc    = 1'b0;
      case (state)
         S_IDLE: begin
            if (!ep2_empty) begin
               state_n = S_RD;
               rd_go   = 1'b1;
            end else if (idx != '0) begin
               if (to_cnt == TO_MAX) to_fire = 1'b1;
               else                  to_inc  = 1'b1;
            end
         end
         S_RD:  state_n = S_CAP;
         S_CAP: begin
            store = 1'b1;
            if (idx == LAST_IDX) begin
               last    = 1'b1;
               state_n = S_OUT;
            end else begin
               state_n = S_IDLE;
            end
         end
         S_OUT: begin
            if (frame_ready) begin
               handshake = 1'b1;
               state_n   = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idx         <= '0;
         to_cnt      <= '0;
         ep2_re      <= 1'b0;
         frame_valid <= 1'b0;
         frame_count <= '0;
         timeout_err <= 1'b0;
      end else begin
         ep2_re      <= rd_go;
         timeout_err <= to_fire;
         if (store)                     idx <= idx + IDX_W'(1);
         else if (handshake || to_fire) idx <= '0;
         if (store || to_fire || idx == '0) to_cnt <= '0;
         else if (to_inc)                   to_cnt <= to_cnt + TO_W'(1);
         if (store && last)  frame_valid <= 1'b1;
         else if (handshake) frame_valid <= 1'b0;
         if (handshake) frame_count <= frame_count + 16'd1;
      end
   end

   // Unwritten lanes keep the previous frame's bytes; only the addressed lane loads.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         frame_data <= '0;
      end else if (store) begin
         for (int i = 0; i < FRAME_BYTES; i++)
            if (idx == IDX_W'(i)) frame_data[8*i +: 8] <= ep2_dout;
      end
   end

`ifdef USB_EP_OUT_LED_EN
   always_ff @(posedge clk_i) begin
      if (rst_i)      led <= LED_RST;
      else if (store) led <= ep2_dout;
   end
`else
   assign led = LED_RST;
`endif

endmodule
